// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
package seg_scan_pkg;

  // Owner FSM; encodings double as the src_sel output value
  typedef enum logic [1:0] {
    BLANK     = 2'b00,
    SHOW_DBG  = 2'b01,
    SHOW_MMIO = 2'b10
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_DBG  = 2'b01;
  localparam logic [1:0] SRC_MMIO = 2'b10;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low segments {a,b,c,d,e,f,g}, indexed by hex nibble
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Active-low one-hot anode select for a digit index
  function automatic logic [7:0] anode_onehot(input logic [2:0] d);
    return ~(8'h01 << d);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-requester seven-segment scan controller: debug has fixed priority over
// MMIO, owners keep the display for at least HOLD frames, and the displayed
// value is snapshotted once per frame so it never tears.
// Optional build macro SEG_SCAN_LZ_BLANK_EN: blank leading-zero digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int HOLD  = 2
) (
  input  logic        clk_7seg,
  input  logic        Rst,
  input  logic        dbg_req,
  input  logic [31:0] dbg_data,
  input  logic        mmio_req,
  input  logic [31:0] mmio_data,
  output logic [7:0]  an,
  output logic [6:0]  sev_out,
  output logic [1:0]  src_sel,
  output logic        frame_done
);

  state_t      state, state_nxt;
  logic [7:0]  dwell;
  logic [2:0]  digit;
  logic [3:0]  hold_cnt;
  logic [31:0] snap;
  logic        last_dwell, frame_end, hold_ok, grant, load_snap, lit;
  logic [31:0] snap_src;
  logic [3:0]  nib;
  logic [6:0]  seg_dec;

  assign last_dwell = (dwell == 8'(DWELL - 1));
  assign frame_end  = last_dwell && (digit == 3'd7);
  assign frame_done = frame_end && !Rst;
  // The frame ending now counts toward HOLD, hence the -1
  assign hold_ok    = (hold_cnt >= 4'(HOLD - 1));

  // Next owner: immediate grant from BLANK, otherwise only at an eligible frame boundary
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      BLANK: begin
        if (dbg_req) begin
          state_nxt = SHOW_DBG;
          grant     = 1'b1;
        end else if (mmio_req) begin
          state_nxt = SHOW_MMIO;
          grant     = 1'b1;
        end
      end
      SHOW_DBG, SHOW_MMIO: begin
        if (frame_end && hold_ok) begin
          if (dbg_req)       state_nxt = SHOW_DBG;
          else if (mmio_req) state_nxt = SHOW_MMIO;
          else               state_nxt = BLANK;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Owner state register
  always_ff @(posedge clk_7seg) begin
    if (Rst) state <= BLANK;
    else     state <= state_nxt;
  end

  // Snapshot loads on the edge that enters digit 0/dwell 0 for the incoming owner
  assign load_snap = (grant || frame_end) && (state_nxt != BLANK);
  assign snap_src  = (state_nxt == SHOW_DBG) ? dbg_data : mmio_data;

  // Scan counters, hold counter and frame snapshot
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      dwell    <= '0;
      digit    <= '0;
      hold_cnt <= '0;
      snap     <= '0;
    end else begin
      if (grant) begin
        dwell <= '0;
        digit <= '0;
      end else if (last_dwell) begin
        dwell <= '0;
        digit <= digit + 3'd1;
      end else begin
        dwell <= dwell + 8'd1;
      end
      if (state_nxt != state)
        hold_cnt <= '0;
      else if (frame_end && (state != BLANK) && (hold_cnt != 4'(HOLD)))
        hold_cnt <= hold_cnt + 4'd1;
      if (load_snap) snap <= snap_src;
    end
  end

  assign nib = snap[{digit, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [2:0] msd;
  // Highest nonzero nibble; digit 0 stays lit even for an all-zero value
  always_comb begin
    msd = '0;
    for (int i = 1; i < 8; i++)
      if (snap[4*i +: 4] != 4'h0) msd = 3'(i);
  end
  assign lit = (digit <= msd);
`else
  assign lit = 1'b1;
`endif

  // Registered drive: outputs trail the digit index by one cycle
  always_ff @(posedge clk_7seg) begin
    if (Rst || state == BLANK) begin
      an      <= ANODE_OFF;
      sev_out <= SEG_OFF;
    end else begin
      an      <= lit ? anode_onehot(digit) : ANODE_OFF;
      sev_out <= seg_dec;
    end
  end

  // Owner report
  always_comb begin
    src_sel = SRC_NONE;
    unique case (state)
      SHOW_DBG:  src_sel = SRC_DBG;
      SHOW_MMIO: src_sel = SRC_MMIO;
      default:   src_sel = SRC_NONE;
    endcase
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl (DWELL=4, HOLD=2).
module tb_seg_scan_ctrl;

  logic        clk_7seg = 1'b0;
  logic        Rst;
  logic        dbg_req, mmio_req;
  logic [31:0] dbg_data, mmio_data;
  logic [7:0]  an;
  logic [6:0]  sev_out;
  logic [1:0]  src_sel;
  logic        frame_done;

  seg_scan_ctrl dut (
    .clk_7seg   (clk_7seg),
    .Rst        (Rst),
    .dbg_req    (dbg_req),
    .dbg_data   (dbg_data),
    .mmio_req   (mmio_req),
    .mmio_data  (mmio_data),
    .an         (an),
    .sev_out    (sev_out),
    .src_sel    (src_sel),
    .frame_done (frame_done)
  );

  always #5 clk_7seg = ~clk_7seg;

  typedef struct {
    string      tag;
    logic [7:0] an;
    logic [6:0] sev;
    logic [1:0] src;
    logic       fd;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] lag_an  = 8'hFF;
  logic [6:0] lag_sev = 7'h7F;

  logic [6:0] lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [7:0] exp_an(input logic [31:0] data, input int d);
    logic [7:0] a;
    int top;
    a = 8'hFF;
    a[3'(d)] = 1'b0;
    top = 7;
`ifdef SEG_SCAN_LZ_BLANK_EN
    top = 0;
    for (int i = 0; i < 8; i++) if (data[4*i +: 4] != 4'h0) top = i;
`endif
    if (d > top) a = 8'hFF;
    return a;
  endfunction

  // One expected cycle: outputs show what the previous cycle selected
  task automatic push_cyc(input string tag, input logic [1:0] src,
                          input logic [31:0] data, input int d, input logic fd);
    exp_t e;
    e.tag = tag; e.an = lag_an; e.sev = lag_sev; e.src = src; e.fd = fd;
    q.push_back(e);
    if (src != 2'b00) begin
      lag_an  = exp_an(data, d);
      lag_sev = lut[data[4*d +: 4]];
    end else begin
      lag_an  = 8'hFF;
      lag_sev = 7'h7F;
    end
  endtask

  task automatic push_rst(input string tag);
    exp_t e;
    e.tag = tag; e.an = 8'hFF; e.sev = 7'h7F; e.src = 2'b00; e.fd = 1'b0;
    q.push_back(e);
    lag_an  = 8'hFF;
    lag_sev = 7'h7F;
  endtask

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk_7seg);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $error("FAIL scoreboard_empty: got an=%h, required an expected entry", an);
      end else begin
        e = q.pop_front();
        assert ({an, sev_out, src_sel, frame_done} === {e.an, e.sev, e.src, e.fd})
        else begin
          n_fail++;
          $error("FAIL %s: got an=%h sev=%b src=%b fd=%b, required an=%h sev=%b src=%b fd=%b",
                 e.tag, an, sev_out, src_sel, frame_done, e.an, e.sev, e.src, e.fd);
        end
      end
    end
  endtask

  // Push positions p0..p0+n-1 of a frame, then check them cycle by cycle
  task automatic seg(input string tag, input logic [1:0] src,
                     input logic [31:0] data, input int p0, input int n);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (p0 + k) % 32;
      push_cyc(tag, src, data, p / 4, p == 31);
    end
    run(n);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; dbg_req = 1'b0; mmio_req = 1'b0; dbg_data = '0; mmio_data = '0;
    // Reset, then two idle frames
    repeat (3) push_rst("reset");
    run(3);
    Rst = 1'b0;
    seg("idle", 2'b00, 32'h0, 1, 63);

    // MMIO grant; tear-free snapshot across frames; release to BLANK
    mmio_req = 1'b1; mmio_data = 32'h1234ABCD;
    seg("mmio_f1", 2'b10, 32'h1234ABCD, 0, 13);
    mmio_data = 32'h0;
    seg("mmio_f1", 2'b10, 32'h1234ABCD, 13, 19);
    seg("tear_zero", 2'b10, 32'h0, 0, 13);
    mmio_data = 32'hFFFF_FFFF;
    seg("tear_zero", 2'b10, 32'h0, 13, 19);
    seg("tear_ff", 2'b10, 32'hFFFF_FFFF, 0, 13);
    mmio_req = 1'b0;
    seg("tear_ff", 2'b10, 32'hFFFF_FFFF, 13, 19);
    seg("mmio_release", 2'b00, 32'h0, 0, 10);

    // Mid-frame grant restarts the scan; debug preempts only after HOLD frames
    mmio_req = 1'b1; mmio_data = 32'h0000_5A00;
    seg("regrant_mmio", 2'b10, 32'h0000_5A00, 0, 16);
    dbg_req = 1'b1; dbg_data = 32'h0000_00F0;
    seg("hold_f1", 2'b10, 32'h0000_5A00, 16, 16);
    seg("hold_f2", 2'b10, 32'h0000_5A00, 0, 32);
    seg("dbg_f1", 2'b01, 32'h0000_00F0, 0, 32);
    seg("dbg_f2", 2'b01, 32'h0000_00F0, 0, 21);

    // Reset during digit 5, then re-grant of the pending debug request
    Rst = 1'b1;
    push_rst("mid_reset");
    push_rst("mid_reset");
    run(2);
    Rst = 1'b0;
    seg("dbg_regrant", 2'b01, 32'h0000_00F0, 0, 32);
    seg("dbg_r2", 2'b01, 32'h0000_00F0, 0, 32);
    seg("dbg_r3", 2'b01, 32'h0000_00F0, 0, 13);
    dbg_req = 1'b0; mmio_req = 1'b0;
    seg("dbg_r3", 2'b01, 32'h0000_00F0, 13, 19);
    seg("dbg_release", 2'b00, 32'h0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
